reg_bank_sequencer: RTL and testbench
=====================================

// Module: reg_bank_sequencer
// PURPOSE
//  Multi-cycle command sequencer for the 8x8 register bank (two one-hot read ports, one one-hot write port).
//  Accepts register-to-register commands over a valid/ready handshake.
//  Drives the bank's read masks, captures both read buses, computes the result and drives the masked write.
//  Sits between core decode and the register bank. It is the sole driver of the bank's mask, data and setter inputs.
// PARAMETERS
//  NREGS  8  number of bank registers; width of every one-hot mask
//  WIDTH  8  register/data width
//  IDXW   $clog2(NREGS)  register index width (local, derived)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      sequencer can accept (high only in IDLE)
//  cmd_op       in   3      0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SWAP
//  cmd_src_a    in   IDXW   source A index
//  cmd_src_b    in   IDXW   source B index
//  cmd_dst      in   IDXW   destination index (ignored by NOP/SWAP)
//  done         out  1      one-cycle pulse when the command's last cycle is driven
//  rb_mask_a    out  NREGS  one-hot read mask, port A
//  rb_mask_b    out  NREGS  one-hot read mask, port B
//  rb_bus_a     in   WIDTH  bank read data, port A (combinational from the masks)
//  rb_bus_b     in   WIDTH  bank read data, port B
//  rb_wr_data   out  WIDTH  write data
//  rb_wr_mask   out  NREGS  one-hot write mask
//  rb_setter    out  1      write strobe; the bank writes on the clk edge that ends a cycle with it high
//  flag_z       out  1      result == 0 (see CONFIGURATION)
//  flag_c       out  1      ADD carry-out / SUB borrow (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; captured operands 0.
//  Handshake: accept when cmd_valid && cmd_ready. Latch op and indices. cmd_ready drops the next cycle.
//  FSM: IDLE -> READ -> WRITE -> IDLE; SWAP only: WRITE -> WRITE2 -> IDLE; NOP: IDLE -> DONE -> IDLE.
//  READ (T+1): rb_mask_a/b = one-hot(src_a/src_b). Capture rb_bus_a/b into op_a/op_b at the end of the cycle.
//  WRITE (T+2): rb_setter=1, rb_wr_mask=one-hot(dst), rb_wr_data=alu(op_a,op_b); done=1 unless SWAP.
//  SWAP: WRITE drives mask=one-hot(src_a), data=op_b. WRITE2 (T+3) drives mask=one-hot(src_b), data=op_a, done=1.
//  NOP: DONE state (T+1) drives done=1; setter and all masks stay 0.
//  Latency: result in the bank after the T+2 edge (SWAP: T+3). Back-to-back commands: next accept at T+3 (SWAP T+4).
//  Masks are 0 outside READ. wr_mask/wr_data/setter are 0 outside WRITE/WRITE2 (no stale drive).
//  ALU is WIDTH wide with modulo wrap: ADD 0xFF+0x01 = 0x00, c=1; SUB 0x00-0x01 = 0xFF, c=1 (borrow).
//  src_a==src_b and dst equal to a source are legal: operands are captured before the write.
//  SWAP with src_a==src_b performs two writes of the same value; no corruption.
//  Reset mid-command: abort at that edge. No write is issued after reset; a partial SWAP leaves only the first write.
//  cmd_* inputs are ignored outside IDLE.
// CONFIGURATION
//  RB_SEQ_FLAGS_EN defined: flag_z/flag_c are registered on the WRITE edge of ADD/SUB/AND/OR/XOR and hold until the next such op or reset.
//    AND/OR/XOR clear c. MOV/SWAP/NOP leave both flags unchanged.
//  RB_SEQ_FLAGS_EN undefined: flag_z=flag_c=0 constant; no flag registers.
// STRUCTURE
//  Package rb_seq_pkg: op codes (OP_NOP..OP_SWAP), FSM state encoding, function onehot(idx) -> NREGS mask.
//  Sub-module rb_seq_alu (combinational: op, a, b -> result, carry). The FSM and capture registers stay in reg_bank_sequencer.
// TESTING  (bench includes a behavioural 8x8 register bank model)
//  Preload r1=0x0F, r2=0x01; ADD dst=r3 -> done at T+2, r3=0x10, z=0, c=0, r1/r2 unchanged.
//  r4=0xFF, r5=0x01; ADD dst=r4 -> r4=0x00, z=1, c=1. Then SUB r6=0x00 - r5 -> 0xFF, c=1.
//  r1=0xAA, r2=0x55; SWAP a=1 b=2 -> setter high T+2 and T+3, done only T+3, r1=0x55, r2=0xAA.
//  cmd_valid held high with 3 MOVs -> accepts spaced 3 cycles; cmd_ready low during READ/WRITE.
//  Assert rst during SWAP's WRITE cycle -> one write only, next cycle all outputs 0, cmd_ready=1.
//  NOP -> done at T+1, setter never high. Flags build without RB_SEQ_FLAGS_EN -> flags constant 0.

Source files
------------

// File: rtl/rb_seq_pkg.sv
// Shared definitions for the register-bank sequencer: op codes, FSM states, one-hot helper.
// The optional flag registers are enabled with RB_SEQ_FLAGS_EN (see reg_bank_sequencer).
package rb_seq_pkg;

    localparam int unsigned RB_NREGS = 8;
    localparam int unsigned RB_WIDTH = 8;
    localparam int unsigned RB_IDXW  = $clog2(RB_NREGS);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWrite2,
        StDone
    } state_e;

    function automatic logic [RB_NREGS-1:0] onehot(input logic [RB_IDXW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rb_seq_alu.sv
// Combinational ALU for the sequencer: WIDTH-bit modulo arithmetic, carry = ADD carry-out or
// SUB borrow, zero for every other op.
module rb_seq_alu
    import rb_seq_pkg::*;
#(
    parameter int unsigned WIDTH = RB_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] wide;

    // The extra top bit of a zero-extended subtraction is exactly the borrow.
    always_comb begin
        wide = '0;
        case (op)
            OP_MOV:  wide = {1'b0, a};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
    end

    assign result = wide[WIDTH-1:0];
    assign carry  = wide[WIDTH];

endmodule

// File: rtl/reg_bank_sequencer.sv
// Multi-cycle register-to-register command sequencer driving an 8x8 one-hot register bank.
// Define RB_SEQ_FLAGS_EN to build the registered zero/carry flags; otherwise they read 0.
module reg_bank_sequencer
    import rb_seq_pkg::*;
#(
    parameter  int unsigned NREGS = RB_NREGS,
    parameter  int unsigned WIDTH = RB_WIDTH,
    localparam int unsigned IDXW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_src_a,
    input  logic [IDXW-1:0]  cmd_src_b,
    input  logic [IDXW-1:0]  cmd_dst,
    output logic             done,
    output logic [NREGS-1:0] rb_mask_a,
    output logic [NREGS-1:0] rb_mask_b,
    input  logic [WIDTH-1:0] rb_bus_a,
    input  logic [WIDTH-1:0] rb_bus_b,
    output logic [WIDTH-1:0] rb_wr_data,
    output logic [NREGS-1:0] rb_wr_mask,
    output logic             rb_setter,
    output logic             flag_z,
    output logic             flag_c
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [IDXW-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    rb_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

`ifdef RB_SEQ_FLAGS_EN
    logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_alu_carry;
    assign unused_alu_carry = alu_carry;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OP_NOP;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
`ifdef RB_SEQ_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
`ifdef RB_SEQ_FLAGS_EN
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        dst_d      = dst_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        rb_mask_a  = '0;
        rb_mask_b  = '0;
        rb_setter  = 1'b0;
        rb_wr_mask = '0;
        rb_wr_data = '0;
`ifdef RB_SEQ_FLAGS_EN
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
`endif
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    state_d = (op_e'(cmd_op) == OP_NOP) ? StDone : StRead;
                end
            end
            StRead: begin
                rb_mask_a = onehot(src_a_q);
                rb_mask_b = onehot(src_b_q);
                op_a_d    = rb_bus_a;
                op_b_d    = rb_bus_b;
                state_d   = StWrite;
            end
            StWrite: begin
                rb_setter = 1'b1;
                if (op_q == OP_SWAP) begin
                    rb_wr_mask = onehot(src_a_q);
                    rb_wr_data = op_b_q;
                    state_d    = StWrite2;
                end else begin
                    rb_wr_mask = onehot(dst_q);
                    rb_wr_data = alu_result;
                    done       = 1'b1;
                    state_d    = StIdle;
`ifdef RB_SEQ_FLAGS_EN
                    if (op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) begin
                        flag_z_d = (alu_result == '0);
                        flag_c_d = alu_carry;
                    end
`endif
                end
            end
            StWrite2: begin
                rb_setter  = 1'b1;
                rb_wr_mask = onehot(src_b_q);
                rb_wr_data = op_a_q;
                done       = 1'b1;
                state_d    = StIdle;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Self-checking bench for reg_bank_sequencer with a behavioural 8x8 register bank and a
// command-level reference model; honours RB_SEQ_FLAGS_EN for the flag expectations.
module tb_reg_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
    logic       done;
    logic [7:0] rb_mask_a, rb_mask_b, rb_wr_mask;
    logic [7:0] rb_bus_a, rb_bus_b, rb_wr_data;
    logic       rb_setter, flag_z, flag_c;

    logic [7:0] bank [8];
    logic       pre_we = 1'b0;
    logic [2:0] pre_idx = '0;
    logic [7:0] pre_val = '0;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    reg_bank_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .done       (done),
        .rb_mask_a  (rb_mask_a),
        .rb_mask_b  (rb_mask_b),
        .rb_bus_a   (rb_bus_a),
        .rb_bus_b   (rb_bus_b),
        .rb_wr_data (rb_wr_data),
        .rb_wr_mask (rb_wr_mask),
        .rb_setter  (rb_setter),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    always #5 clk = ~clk;

    // Register bank: combinational one-hot reads, write on the edge ending a setter cycle.
    always_comb begin
        rb_bus_a = '0;
        rb_bus_b = '0;
        for (int i = 0; i < 8; i++) begin
            if (rb_mask_a[i]) rb_bus_a = rb_bus_a | bank[i];
            if (rb_mask_b[i]) rb_bus_b = rb_bus_b | bank[i];
        end
    end

    always @(posedge clk) begin
        if (pre_we) bank[pre_idx] <= pre_val;
        else if (rb_setter)
            for (int i = 0; i < 8; i++) if (rb_wr_mask[i]) bank[i] <= rb_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: cycle offset since acceptance plus architectural register values.
    int         ph = 0;
    logic [2:0] m_op;
    int         m_sa, m_sb, m_dst;
    logic [7:0] m_a, m_b, m_res;
    logic       m_cout, m_z = 1'b0, m_c = 1'b0;
    logic [7:0] mdl [8];

    always @(negedge clk) begin
        logic       e_ready, e_done, e_set, e_fz, e_fc;
        logic [7:0] e_ma, e_mb, e_wm, e_wd;
        e_ready = (ph == 0);
        e_done = 1'b0; e_set = 1'b0;
        e_ma = '0; e_mb = '0; e_wm = '0; e_wd = '0;
        if (ph == 1 && m_op == 3'd0) e_done = 1'b1;
        else if (ph == 1) begin
            e_ma = 8'(1 << m_sa);
            e_mb = 8'(1 << m_sb);
        end else if (ph == 2) begin
            e_set = 1'b1;
            if (m_op == 3'd7) begin
                e_wm = 8'(1 << m_sa);
                e_wd = m_b;
            end else begin
                e_wm   = 8'(1 << m_dst);
                e_wd   = m_res;
                e_done = 1'b1;
            end
        end else if (ph == 3) begin
            e_set  = 1'b1;
            e_wm   = 8'(1 << m_sb);
            e_wd   = m_a;
            e_done = 1'b1;
        end
`ifdef RB_SEQ_FLAGS_EN
        e_fz = m_z; e_fc = m_c;
`else
        e_fz = 1'b0; e_fc = 1'b0;
`endif
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            check("done", 32'(done), 32'(e_done));
            check("rb_mask_a", 32'(rb_mask_a), 32'(e_ma));
            check("rb_mask_b", 32'(rb_mask_b), 32'(e_mb));
            check("rb_setter", 32'(rb_setter), 32'(e_set));
            check("rb_wr_mask", 32'(rb_wr_mask), 32'(e_wm));
            check("rb_wr_data", 32'(rb_wr_data), 32'(e_wd));
            check("flag_z", 32'(flag_z), 32'(e_fz));
            check("flag_c", 32'(flag_c), 32'(e_fc));
        end
        // Effects of the coming rising edge.
        if (e_set) for (int i = 0; i < 8; i++) if (e_wm[i]) mdl[i] = e_wd;
        if (pre_we) mdl[pre_idx] = pre_val;
        if (rst) begin
            ph = 0; m_z = 1'b0; m_c = 1'b0;
        end else if (ph == 0) begin
            if (cmd_valid) begin
                m_op = cmd_op; m_sa = int'(cmd_src_a); m_sb = int'(cmd_src_b);
                m_dst = int'(cmd_dst);
                m_a = mdl[m_sa]; m_b = mdl[m_sb]; m_cout = 1'b0;
                case (m_op)
                    3'd1: m_res = m_a;
                    3'd2: {m_cout, m_res} = {1'b0, m_a} + {1'b0, m_b};
                    3'd3: begin m_res = m_a - m_b; m_cout = (m_a < m_b); end
                    3'd4: m_res = m_a & m_b;
                    3'd5: m_res = m_a | m_b;
                    3'd6: m_res = m_a ^ m_b;
                    default: m_res = '0;
                endcase
                ph = 1;
            end
        end else begin
            if (ph == 2 && m_op >= 3'd2 && m_op <= 3'd6) begin
                m_z = (m_res == 8'h00);
                m_c = m_cout;
            end
            if ((ph == 1 && m_op == 3'd0) || (ph == 2 && m_op != 3'd7) || ph == 3) ph = 0;
            else ph = ph + 1;
        end
    end

    task automatic preload(input int idx, input logic [7:0] val);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = 3'(idx); pre_val = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Offer one command; optionally measure cycles from acceptance to the done pulse.
    task automatic do_cmd(input logic [2:0] op, input int sa, input int sb, input int dst,
                          input bit wait_done, output int lat);
        bit acc = 1'b0;
        bit got = 1'b0;
        @(posedge clk); #1;
        cmd_op = op; cmd_src_a = 3'(sa); cmd_src_b = 3'(sb); cmd_dst = 3'(dst);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        lat = 0;
        if (wait_done && acc) begin
            for (int k = 1; k <= 8 && !got; k++) begin
                @(negedge clk);
                if (done) begin lat = k; got = 1'b1; end
            end
            if (!got) check("done_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    int lat;
    int acc_cyc [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_setter", 32'(rb_setter), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) preload(i, 8'h00);

        // ADD 0x0F + 0x01 -> r3
        preload(1, 8'h0F); preload(2, 8'h01);
        do_cmd(3'd2, 1, 2, 3, 1'b1, lat);
        check("add_lat", 32'(lat), 32'd2);
        check("add_r3", 32'(bank[3]), 32'h10);
        check("add_r1", 32'(bank[1]), 32'h0F);
        check("add_r2", 32'(bank[2]), 32'h01);
        check("add_z", 32'(flag_z), 32'd0);
        check("add_c", 32'(flag_c), 32'd0);

        // ADD wrap 0xFF + 0x01, then SUB 0x00 - 0x01
        preload(4, 8'hFF); preload(5, 8'h01);
        do_cmd(3'd2, 4, 5, 4, 1'b1, lat);
        check("wrap_r4", 32'(bank[4]), 32'h00);
`ifdef RB_SEQ_FLAGS_EN
        check("wrap_z", 32'(flag_z), 32'd1);
        check("wrap_c", 32'(flag_c), 32'd1);
`else
        check("wrap_z_off", 32'(flag_z), 32'd0);
        check("wrap_c_off", 32'(flag_c), 32'd0);
`endif
        preload(6, 8'h00);
        do_cmd(3'd3, 6, 5, 6, 1'b1, lat);
        check("sub_r6", 32'(bank[6]), 32'hFF);
`ifdef RB_SEQ_FLAGS_EN
        check("sub_c", 32'(flag_c), 32'd1);
        check("sub_z", 32'(flag_z), 32'd0);
`endif

        // SWAP
        preload(1, 8'hAA); preload(2, 8'h55);
        do_cmd(3'd7, 1, 2, 0, 1'b1, lat);
        check("swap_lat", 32'(lat), 32'd3);
        check("swap_r1", 32'(bank[1]), 32'h55);
        check("swap_r2", 32'(bank[2]), 32'hAA);

        // NOP
        do_cmd(3'd0, 0, 0, 0, 1'b1, lat);
        check("nop_lat", 32'(lat), 32'd1);

        // cmd_valid held high across three MOVs
        @(posedge clk); #1;
        cmd_op = 3'd1; cmd_src_a = 3'd1; cmd_src_b = 3'd0; cmd_dst = 3'd7; cmd_valid = 1'b1;
        begin
            int n = 0;
            for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
                @(negedge clk);
                if (cmd_ready) begin acc_cyc[n] = cyc; n++; end
                @(posedge clk); #1;
                cmd_dst = 3'(7 - n);
            end
            cmd_valid = 1'b0;
            check("b2b_count", 32'(n), 32'd3);
        end
        check("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        repeat (3) @(posedge clk); #1;
        check("b2b_r5", 32'(bank[5]), 32'h55);

        // Reset during SWAP's first write cycle
        preload(1, 8'h11); preload(2, 8'h22);
        do_cmd(3'd7, 1, 2, 0, 1'b0, lat);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_setter", 32'(rb_setter), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_r1", 32'(bank[1]), 32'h22);
        check("rst_r2", 32'(bank[2]), 32'h22);

        // Randomised commands
        for (int n = 0; n < 150; n++) begin
            logic [2:0] op;
            int exp_lat;
            if ($urandom_range(0, 3) == 0) preload(int'($urandom_range(0, 7)), 8'($urandom));
            op = 3'($urandom_range(0, 7));
            exp_lat = (op == 3'd0) ? 1 : (op == 3'd7) ? 3 : 2;
            do_cmd(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'b1, lat);
            check("rand_lat", 32'(lat), 32'(exp_lat));
        end
        for (int i = 0; i < 8; i++) check("final_bank", 32'(bank[i]), 32'(mdl[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
